washer_actuator_ctrl: RTL and testbench

Downstream stage of the washing-machine cycle FSM. Consumes the 3-bit cycle-state code and the 2-bit water-select code, and drives the physical actuators: hot/cold valves, drain pump, motor enable/direction/speed, and door lock. Closes the loop with level and door sensors. Returns a one-cycle `phase_done` pulse upstream when the current step's physical work is complete. Latches a fault on fill or drain timeout.

---
 rtl/washer_pkg.sv | 48 ++++
 rtl/wm_phase_timer.sv | 41 ++++
 rtl/washer_actuator_ctrl.sv | 248 ++++++++++++++++++++++++
 tb/tb_washer_actuator_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/washer_pkg.sv
// Shared definitions for the washer actuator stage.
// Holds the cycle-state codes, which the upstream cycle FSM also uses, the actuator
// FSM state enum, the water-select bit indices, the timer width, and small helpers.
package washer_pkg;

  localparam int unsigned CS_W    = 3;
  localparam int unsigned TIMER_W = 16;

  // Cycle-state codes driven by the upstream FSM
  localparam logic [CS_W-1:0] CS_OFF           = 3'd0;
  localparam logic [CS_W-1:0] CS_IDLE          = 3'd1;
  localparam logic [CS_W-1:0] CS_WASH_FILL     = 3'd2;
  localparam logic [CS_W-1:0] CS_WASH_AGITATE  = 3'd3;
  localparam logic [CS_W-1:0] CS_WASH_SPIN     = 3'd4;
  localparam logic [CS_W-1:0] CS_RINSE_FILL    = 3'd5;
  localparam logic [CS_W-1:0] CS_RINSE_AGITATE = 3'd6;
  localparam logic [CS_W-1:0] CS_RINSE_SPIN    = 3'd7;

  // Bit positions in the water-select code
  localparam int unsigned WATER_HOT  = 1;
  localparam int unsigned WATER_COLD = 0;

  typedef enum logic [2:0] {
    A_IDLE,
    A_FILL,
    A_AGITATE,
    A_DRAIN,
    A_SPIN,
    A_FAULT
  } act_state_e;

  // Entry state of the actuator FSM for a given cycle code
  function automatic act_state_e map_cycle_state(input logic [CS_W-1:0] cs);
    case (cs)
      CS_OFF, CS_IDLE:                   return A_IDLE;
      CS_WASH_FILL, CS_RINSE_FILL:       return A_FILL;
      CS_WASH_AGITATE, CS_RINSE_AGITATE: return A_AGITATE;
      CS_WASH_SPIN, CS_RINSE_SPIN:       return A_DRAIN;
      default:                           return A_IDLE;
    endcase
  endfunction

  // The door is held locked in every working state
  function automatic logic locks_door(input act_state_e s);
    return (s != A_IDLE) && (s != A_FAULT);
  endfunction

endpackage

// File: rtl/wm_phase_timer.sv
// Loadable saturating down-counter.
// Ports: clk, rst (async, active-high); load_i/load_val_i reload the count (load wins
// over hold); hold_i freezes it; expired_o (registered) is high while the count is zero.
// Loading N-1 makes expired_o rise on the Nth cycle after the load.
module wm_phase_timer
  import washer_pkg::*;
#(
  parameter int unsigned W = TIMER_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         hold_i,
  output logic         expired_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // Next count: reload, freeze, or decrement toward zero and stay there
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (!hold_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // Reset leaves the counter saturated (expired)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      expired_o <= 1'b1;
    end else begin
      cnt_q     <= cnt_d;
      expired_o <= (cnt_d == '0);
    end
  end

endmodule

// File: rtl/washer_actuator_ctrl.sv
// Washer actuator stage: turns the upstream cycle code into valve, pump, motor and
// door-lock drives, closes the loop on level and door sensors, pulses phase_done when
// a step's physical work is complete, and latches fault on fill or drain timeout.
// Ports: clk, rst (async, active-high); state (cycle code), water (hot/cold select),
// level_full, level_empty, door_closed (sensors); hot_valve, cold_valve, drain_pump,
// motor_en, motor_dir, motor_speed, door_lock, phase_done, fault (all registered).
// Build option: define WM_SPIN_RAMP_EN to ramp spin speed 1->2->3; otherwise spin
// starts directly at speed 3.
module washer_actuator_ctrl
  import washer_pkg::*;
#(
  parameter int unsigned FILL_TIMEOUT   = 1024,
  parameter int unsigned DRAIN_TIMEOUT  = 512,
  parameter int unsigned AGITATE_HALF   = 16,
  parameter int unsigned AGITATE_CYCLES = 256,
  parameter int unsigned SPIN_RAMP      = 32,
  parameter int unsigned SPIN_CYCLES    = 256,
  parameter int unsigned UNLOCK_DELAY   = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [CS_W-1:0] state,
  input  logic [1:0]      water,
  input  logic            level_full,
  input  logic            level_empty,
  input  logic            door_closed,
  output logic            hot_valve,
  output logic            cold_valve,
  output logic            drain_pump,
  output logic            motor_en,
  output logic            motor_dir,
  output logic [1:0]      motor_speed,
  output logic            door_lock,
  output logic            phase_done,
  output logic            fault
);

  // Timer loads are N-1 so that expiry lands on the Nth cycle in the state
  localparam logic [TIMER_W-1:0] FILL_LOAD   = TIMER_W'(FILL_TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] DRAIN_LOAD  = TIMER_W'(DRAIN_TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] HALF_LOAD   = TIMER_W'(AGITATE_HALF - 1);
  localparam logic [TIMER_W-1:0] AGI_LOAD    = TIMER_W'(AGITATE_CYCLES - 1);
  localparam logic [TIMER_W-1:0] RAMP_LOAD   = TIMER_W'(SPIN_RAMP - 1);
  localparam logic [TIMER_W-1:0] SPIN_LOAD   = TIMER_W'(SPIN_CYCLES - 1);
  localparam logic [TIMER_W-1:0] UNLOCK_LOAD = TIMER_W'(UNLOCK_DELAY - 1);

`ifdef WM_SPIN_RAMP_EN
  localparam logic [1:0]         SPIN_START_SPEED = 2'd1;
  localparam logic [TIMER_W-1:0] SPIN_START_LOAD  = RAMP_LOAD;
`else
  localparam logic [1:0]         SPIN_START_SPEED = 2'd3;
  localparam logic [TIMER_W-1:0] SPIN_START_LOAD  = SPIN_LOAD;
`endif

  logic [CS_W-1:0]    state_q;
  act_state_e         fsm_q, fsm_d, restart_tgt;
  logic               done_q, done_d;
  logic               dir_q, dir_d;
  logic               gap_q, gap_d;
  logic [1:0]         speed_q, speed_d;
  logic               pdone_d;
  logic               state_chg, hold;
  logic               ph_load, half_load, ul_load;
  logic [TIMER_W-1:0] ph_val;
  logic               ph_exp, half_exp, ul_exp;
  logic               hot_d, cold_d, pump_d, men_d, mdir_d, lock_d, fault_d;
  logic [1:0]         mspd_d;

  assign state_chg   = (state != state_q);
  assign restart_tgt = map_cycle_state(state);
  // An open door outside idle freezes all progress
  assign hold        = !door_closed && (fsm_q != A_IDLE);
  // Unlock delay restarts on every FSM transition and is held off while working
  assign ul_load     = locks_door(fsm_q) || (fsm_d != fsm_q);

  wm_phase_timer u_phase_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (ph_load),
    .load_val_i (ph_val),
    .hold_i     (hold),
    .expired_o  (ph_exp)
  );

  wm_phase_timer u_half_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (half_load),
    .load_val_i (HALF_LOAD),
    .hold_i     (hold),
    .expired_o  (half_exp)
  );

  wm_phase_timer u_unlock_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (ul_load),
    .load_val_i (UNLOCK_LOAD),
    .hold_i     (hold),
    .expired_o  (ul_exp)
  );

  // Actuator FSM next state; a cycle-code change outranks any completion in the same cycle
  always_comb begin
    fsm_d     = fsm_q;
    done_d    = done_q;
    dir_d     = dir_q;
    gap_d     = gap_q;
    speed_d   = speed_q;
    pdone_d   = 1'b0;
    ph_load   = 1'b0;
    ph_val    = '0;
    half_load = 1'b0;
    if (fsm_q == A_FAULT) begin
      if (state == CS_OFF) begin
        fsm_d  = A_IDLE;
        done_d = 1'b0;
      end
    end else if (state_chg) begin
      fsm_d     = restart_tgt;
      done_d    = 1'b0;
      dir_d     = 1'b0;
      gap_d     = 1'b0;
      speed_d   = 2'd0;
      ph_load   = 1'b1;
      half_load = 1'b1;
      case (restart_tgt)
        A_FILL:    ph_val = FILL_LOAD;
        A_AGITATE: ph_val = AGI_LOAD;
        A_DRAIN:   ph_val = DRAIN_LOAD;
        default:   ph_val = '0;
      endcase
    end else if (!hold && !done_q) begin
      case (fsm_q)
        A_FILL: begin
          if (level_full) begin
            done_d  = 1'b1;
            pdone_d = 1'b1;
          end else if (ph_exp) begin
            fsm_d = A_FAULT;
          end
        end
        A_AGITATE: begin
          if (ph_exp) begin
            done_d  = 1'b1;
            pdone_d = 1'b1;
            gap_d   = 1'b0;
          end else if (half_exp) begin
            // Reverse, with a one-cycle motor gap on the first cycle of each new half
            dir_d     = !dir_q;
            gap_d     = 1'b1;
            half_load = 1'b1;
          end else begin
            gap_d = 1'b0;
          end
        end
        A_DRAIN: begin
          if (level_empty) begin
            fsm_d   = A_SPIN;
            speed_d = SPIN_START_SPEED;
            ph_load = 1'b1;
            ph_val  = SPIN_START_LOAD;
          end else if (ph_exp) begin
            fsm_d = A_FAULT;
          end
        end
        A_SPIN: begin
          if (ph_exp) begin
            if (speed_q == 2'd3) begin
              done_d  = 1'b1;
              pdone_d = 1'b1;
            end else begin
              speed_d = speed_q + 2'd1;
              ph_load = 1'b1;
              ph_val  = (speed_q == 2'd2) ? SPIN_LOAD : RAMP_LOAD;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Actuator drives from the current FSM state; an open door forces them off
  always_comb begin
    hot_d   = door_closed && (fsm_q == A_FILL) && !done_q && water[WATER_HOT];
    cold_d  = door_closed && (fsm_q == A_FILL) && !done_q && water[WATER_COLD];
    pump_d  = door_closed && ((fsm_q == A_DRAIN) || ((fsm_q == A_SPIN) && !done_q));
    men_d   = door_closed && !done_q &&
              (((fsm_q == A_AGITATE) && !gap_q) || (fsm_q == A_SPIN));
    mdir_d  = door_closed && !done_q && (fsm_q == A_AGITATE) && dir_q;
    mspd_d  = 2'd0;
    if (door_closed && !done_q) begin
      if (fsm_q == A_AGITATE) begin
        mspd_d = 2'd1;
      end else if (fsm_q == A_SPIN) begin
        mspd_d = speed_q;
      end
    end
    lock_d  = locks_door(fsm_q) || !ul_exp;
    fault_d = (fsm_q == A_FAULT);
  end

  // Input register and FSM state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= CS_OFF;
      fsm_q      <= A_IDLE;
      done_q     <= 1'b0;
      dir_q      <= 1'b0;
      gap_q      <= 1'b0;
      speed_q    <= 2'd0;
      phase_done <= 1'b0;
    end else begin
      state_q    <= state;
      fsm_q      <= fsm_d;
      done_q     <= done_d;
      dir_q      <= dir_d;
      gap_q      <= gap_d;
      speed_q    <= speed_d;
      phase_done <= pdone_d;
    end
  end

  // Output register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hot_valve   <= 1'b0;
      cold_valve  <= 1'b0;
      drain_pump  <= 1'b0;
      motor_en    <= 1'b0;
      motor_dir   <= 1'b0;
      motor_speed <= 2'd0;
      door_lock   <= 1'b0;
      fault       <= 1'b0;
    end else begin
      hot_valve   <= hot_d;
      cold_valve  <= cold_d;
      drain_pump  <= pump_d;
      motor_en    <= men_d;
      motor_dir   <= mdir_d;
      motor_speed <= mspd_d;
      door_lock   <= lock_d;
      fault       <= fault_d;
    end
  end

endmodule

// File: tb/tb_washer_actuator_ctrl.sv
// Directed bench for washer_actuator_ctrl with default timing parameters.
module tb_washer_actuator_ctrl;

  logic       clk;
  logic       rst;
  logic [2:0] state;
  logic [1:0] water;
  logic       level_full, level_empty, door_closed;
  logic       hot_valve, cold_valve, drain_pump, motor_en, motor_dir;
  logic [1:0] motor_speed;
  logic       door_lock, phase_done, fault;

  int total = 0;
  int bad   = 0;

`ifdef WM_SPIN_RAMP_EN
  localparam int SPIN_TOTAL = 32 + 32 + 256;
`else
  localparam int SPIN_TOTAL = 256;
`endif

  washer_actuator_ctrl #(
    .FILL_TIMEOUT   (1024),
    .DRAIN_TIMEOUT  (512),
    .AGITATE_HALF   (16),
    .AGITATE_CYCLES (256),
    .SPIN_RAMP      (32),
    .SPIN_CYCLES    (256),
    .UNLOCK_DELAY   (64)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .state       (state),
    .water       (water),
    .level_full  (level_full),
    .level_empty (level_empty),
    .door_closed (door_closed),
    .hot_valve   (hot_valve),
    .cold_valve  (cold_valve),
    .drain_pump  (drain_pump),
    .motor_en    (motor_en),
    .motor_dir   (motor_dir),
    .motor_speed (motor_speed),
    .door_lock   (door_lock),
    .phase_done  (phase_done),
    .fault       (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Valves, pump and motor all off
  task automatic chk_drives_off(input string tag);
    chk({tag, "_hot"},   8'(hot_valve),   8'd0);
    chk({tag, "_cold"},  8'(cold_valve),  8'd0);
    chk({tag, "_pump"},  8'(drain_pump),  8'd0);
    chk({tag, "_men"},   8'(motor_en),    8'd0);
    chk({tag, "_mdir"},  8'(motor_dir),   8'd0);
    chk({tag, "_speed"}, 8'(motor_speed), 8'd0);
  endtask

  function automatic logic [1:0] spin_speed(input int j);
`ifdef WM_SPIN_RAMP_EN
    if (j <= 32) return 2'd1;
    if (j <= 64) return 2'd2;
    return 2'd3;
`else
    if (j >= 1) return 2'd3;
    return 2'd0;
`endif
  endfunction

  initial begin
    rst = 1'b1; state = 3'd0; water = 2'b00;
    level_full = 1'b0; level_empty = 1'b0; door_closed = 1'b1;

    // Reset state
    step(2);
    chk_drives_off("rst");
    chk("rst_lock",  8'(door_lock),  8'd0);
    chk("rst_pdone", 8'(phase_done), 8'd0);
    chk("rst_fault", 8'(fault),      8'd0);
    rst = 1'b0;
    step(2);
    chk("idle_lock", 8'(door_lock), 8'd0);

    // Hot fill, two-cycle latency, then level_full completes the step
    state = 3'd2; water = 2'b10;
    step(1);
    chk("fill_lat1_hot", 8'(hot_valve), 8'd0);
    step(1);
    chk("fill_hot",  8'(hot_valve),  8'd1);
    chk("fill_cold", 8'(cold_valve), 8'd0);
    chk("fill_lock", 8'(door_lock),  8'd1);
    level_full = 1'b1;
    step(1);
    chk("fill_pdone", 8'(phase_done), 8'd1);
    step(1);
    chk("fill_pdone_end", 8'(phase_done), 8'd0);
    chk("fill_hot_off",   8'(hot_valve),  8'd0);
    begin
      int pulses = 0;
      for (int i = 0; i < 5; i++) begin
        step(1);
        if (phase_done) pulses++;
      end
      chk("fill_single_pulse", 8'(pulses), 8'd0);
    end

    // State change together with level_full: no pulse on that cycle
    state = 3'd5;
    step(1);
    chk("chg_wins_pdone", 8'(phase_done), 8'd0);
    step(1);
    chk("refill_pdone", 8'(phase_done), 8'd1);
    state = 3'd0; level_full = 1'b0;
    step(3);

    // Cold fill with no level_full: timeout fault
    state = 3'd5; water = 2'b01;
    step(1025);
    chk("to_fault_pre", 8'(fault),      8'd0);
    chk("to_cold_pre",  8'(cold_valve), 8'd1);
    step(1);
    chk("to_fault", 8'(fault), 8'd1);
    chk_drives_off("to");
    chk("to_lock", 8'(door_lock), 8'd1);
    state = 3'd2;
    step(3);
    chk("fault_sticky", 8'(fault),     8'd1);
    chk("fault_hot",    8'(hot_valve), 8'd0);
    state = 3'd0;
    step(1);
    chk("fault_exit_lag", 8'(fault), 8'd1);
    step(1);
    chk("fault_clear", 8'(fault),     8'd0);
    chk("unlock_wait", 8'(door_lock), 8'd1);
    step(62);
    chk("unlock_pre", 8'(door_lock), 8'd1);
    step(1);
    chk("unlock", 8'(door_lock), 8'd0);

    // Agitate: reversal every 16 cycles with a one-cycle enable gap, done at 256
    state = 3'd3;
    step(1);
    chk("agi_lat_men", 8'(motor_en), 8'd0);
    for (int k = 1; k <= 256; k++) begin
      step(1);
      chk($sformatf("agi_men[%0d]", k),   8'(motor_en),    8'((k > 16 && (k - 1) % 16 == 0) ? 0 : 1));
      chk($sformatf("agi_dir[%0d]", k),   8'(motor_dir),   8'(((k - 1) / 16) % 2));
      chk($sformatf("agi_spd[%0d]", k),   8'(motor_speed), 8'd1);
      chk($sformatf("agi_pdone[%0d]", k), 8'(phase_done),  8'((k == 256) ? 1 : 0));
    end
    step(1);
    chk("agi_done_men",   8'(motor_en),    8'd0);
    chk("agi_done_spd",   8'(motor_speed), 8'd0);
    chk("agi_done_pdone", 8'(phase_done),  8'd0);

    // Agitate with the door open for 20 cycles: outputs off, timers frozen
    state = 3'd0;
    step(2);
    state = 3'd6;
    step(101);
    door_closed = 1'b0;
    step(1);
    chk_drives_off("door");
    chk("door_lock_held", 8'(door_lock), 8'd1);
    step(19);
    chk("door_end_men", 8'(motor_en), 8'd0);
    door_closed = 1'b1;
    step(1);
    chk("door_resume_men", 8'(motor_en),    8'd1);
    chk("door_resume_spd", 8'(motor_speed), 8'd1);
    chk("door_resume_dir", 8'(motor_dir),   8'd0);
    step(154);
    chk("door_pdone_pre", 8'(phase_done), 8'd0);
    step(1);
    chk("door_pdone", 8'(phase_done), 8'd1);

    // Drain then spin
    state = 3'd0;
    step(2);
    state = 3'd7;
    step(2);
    chk("drain_pump", 8'(drain_pump), 8'd1);
    chk("drain_men",  8'(motor_en),   8'd0);
    step(8);
    level_empty = 1'b1;
    step(1);
    chk("drain_last_pump", 8'(drain_pump), 8'd1);
    chk("drain_last_men",  8'(motor_en),   8'd0);
    for (int j = 1; j <= SPIN_TOTAL; j++) begin
      step(1);
      chk($sformatf("spin_spd[%0d]", j),   8'(motor_speed), 8'(spin_speed(j)));
      chk($sformatf("spin_pump[%0d]", j),  8'(drain_pump),  8'd1);
      chk($sformatf("spin_men[%0d]", j),   8'(motor_en),    8'd1);
      chk($sformatf("spin_dir[%0d]", j),   8'(motor_dir),   8'd0);
      chk($sformatf("spin_pdone[%0d]", j), 8'(phase_done),  8'((j == SPIN_TOTAL) ? 1 : 0));
    end
    step(1);
    chk("spin_done_pump", 8'(drain_pump),  8'd0);
    chk("spin_done_men",  8'(motor_en),    8'd0);
    chk("spin_done_spd",  8'(motor_speed), 8'd0);

    // Asynchronous reset mid-spin
    state = 3'd0; level_empty = 1'b0;
    step(2);
    state = 3'd4; level_empty = 1'b1;
    step(12);
    chk("pre_rst_pump", 8'(drain_pump), 8'd1);
    chk("pre_rst_men",  8'(motor_en),   8'd1);
    rst = 1'b1;
    #1;
    chk_drives_off("arst");
    chk("arst_lock",  8'(door_lock),  8'd0);
    chk("arst_pdone", 8'(phase_done), 8'd0);
    state = 3'd0; level_empty = 1'b0;
    step(2);
    rst = 1'b0;
    step(1);
    chk_drives_off("post_rst");
    chk("post_rst_lock", 8'(door_lock), 8'd0);
    step(5);
    chk("post_rst_idle_pump", 8'(drain_pump), 8'd0);
    state = 3'd2; water = 2'b11;
    step(2);
    chk("post_rst_hot",  8'(hot_valve),  8'd1);
    chk("post_rst_cold", 8'(cold_valve), 8'd1);
    chk("post_rst_lock_on", 8'(door_lock), 8'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
